// File: rtl/sys_sum_stream.sv
// sys_sum_stream: accumulates (sum or max) D rows of signed channels, then
// serialises the per-channel results highest channel first under ready/valid.
module sys_sum_stream #(
  parameter int BitSize     = 8,
  parameter int OutSize     = 8,
  parameter int NumOfNerves = 4,
  parameter int MaxDepth    = 8,
  parameter bit Saturate    = 1'b1
) (
  input  logic                            clk,
  input  logic                            res,
  input  logic [$clog2(MaxDepth+1)-1:0]   cfg_depth,
  input  logic                            cfg_mode,
  input  logic                            in_valid,
  input  logic                            in_start,
  output logic                            in_ready,
  input  logic [NumOfNerves*BitSize-1:0]  in_data,
  input  logic                            out_ready,
  output logic                            out_valid,
  output logic                            out_start,
  output logic                            out_last,
  output logic [OutSize-1:0]              out_data,
  output logic                            err_restart
);
  localparam int AccSize = BitSize + $clog2(MaxDepth);
  localparam int DW = $clog2(MaxDepth + 1);
  localparam int PW = NumOfNerves > 1 ? $clog2(NumOfNerves) : 1;
  localparam logic signed [AccSize-1:0] SMAX = AccSize'((64'sd1 <<< (OutSize - 1)) - 64'sd1);
  localparam logic signed [AccSize-1:0] SMIN = ~SMAX;

  typedef enum logic {ACCUM, DRAIN} state_t;

  state_t state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d, depth_q, depth_d, dep;
  logic mode_q, mode_d;
  logic signed [AccSize-1:0] acc_q [NumOfNerves];
  logic signed [AccSize-1:0] acc_d [NumOfNerves];
  logic signed [AccSize-1:0] sx [NumOfNerves];
  logic [PW-1:0] ptr_q, ptr_d, sel;
  logic out_valid_d, out_start_d, out_last_d, err_d;
  logic [OutSize-1:0] out_data_d;

  function automatic logic [OutSize-1:0] conv(input logic signed [AccSize-1:0] a);
    return (Saturate && a > SMAX) ? SMAX[OutSize-1:0] :
           (Saturate && a < SMIN) ? SMIN[OutSize-1:0] : a[OutSize-1:0];
  endfunction

  assign in_ready = state_q == ACCUM;

  always_comb begin
    for (int i = 0; i < NumOfNerves; i++)
      sx[i] = AccSize'(signed'(in_data[i*BitSize +: BitSize]));
  end

  always_comb begin
    dep = cfg_depth == '0 ? DW'(1) : cfg_depth > DW'(MaxDepth) ? DW'(MaxDepth) : cfg_depth;
    state_d = state_q;
    cnt_d   = cnt_q;
    depth_d = depth_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    ptr_d   = ptr_q;
    err_d   = 1'b0;
    if (in_valid && in_ready) begin
      if (in_start) begin
        err_d   = cnt_q != '0;
        depth_d = dep;
        mode_d  = cfg_mode;
        cnt_d   = DW'(1);
        acc_d   = sx;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q + 1'b1;
        for (int i = 0; i < NumOfNerves; i++)
          acc_d[i] = mode_q ? (sx[i] > acc_q[i] ? sx[i] : acc_q[i]) : acc_q[i] + sx[i];
      end
      if ((in_start || cnt_q != '0) && cnt_d == depth_d) begin
        state_d = DRAIN;
        ptr_d   = '0;
      end
    end else if (state_q == DRAIN && out_ready) begin
      if (ptr_q == PW'(NumOfNerves - 1)) begin
        state_d = ACCUM;
        cnt_d   = '0;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
    sel         = PW'(NumOfNerves - 1) - ptr_d;
    out_valid_d = state_d == DRAIN;
    out_start_d = out_valid_d && ptr_d == '0;
    out_last_d  = out_valid_d && ptr_d == PW'(NumOfNerves - 1);
    out_data_d  = out_valid_d ? conv(acc_d[sel]) : out_data;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      depth_q     <= DW'(1);
      mode_q      <= 1'b0;
      ptr_q       <= '0;
      for (int i = 0; i < NumOfNerves; i++) acc_q[i] <= '0;
      out_valid   <= 1'b0;
      out_start   <= 1'b0;
      out_last    <= 1'b0;
      out_data    <= '0;
      err_restart <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      depth_q     <= depth_d;
      mode_q      <= mode_d;
      ptr_q       <= ptr_d;
      acc_q       <= acc_d;
      out_valid   <= out_valid_d;
      out_start   <= out_start_d;
      out_last    <= out_last_d;
      out_data    <= out_data_d;
      err_restart <= err_d;
    end
  end
endmodule

// File: tb/tb_sys_sum_stream.sv
// tb_sys_sum_stream: directed and randomized groups checked against an arithmetic
// model; a second instance with saturation disabled checks truncation.
module tb_sys_sum_stream;
  localparam int N = 4;

  logic clk = 1'b0, res = 1'b0;
  logic [3:0] cfg_depth = '0;
  logic cfg_mode = 1'b0, in_valid = 1'b0, in_start = 1'b0, out_ready = 1'b1;
  logic [31:0] in_data = '0;
  logic in_ready, out_valid, out_start, out_last, err_restart;
  logic [7:0] out_data;
  logic in_ready_t, out_valid_t, out_start_t, out_last_t, err_t;
  logic [7:0] out_data_t;

  int checks = 0, failures = 0;
  int m_acc[N];
  int m_cnt = 0, m_depth = 1;
  bit m_mode = 1'b0;

  sys_sum_stream dut (
    .clk(clk), .res(res), .cfg_depth(cfg_depth), .cfg_mode(cfg_mode),
    .in_valid(in_valid), .in_start(in_start), .in_ready(in_ready), .in_data(in_data),
    .out_ready(out_ready), .out_valid(out_valid), .out_start(out_start),
    .out_last(out_last), .out_data(out_data), .err_restart(err_restart)
  );

  sys_sum_stream #(.Saturate(1'b0)) dut_t (
    .clk(clk), .res(res), .cfg_depth(cfg_depth), .cfg_mode(cfg_mode),
    .in_valid(in_valid), .in_start(in_start), .in_ready(in_ready_t), .in_data(in_data),
    .out_ready(out_ready), .out_valid(out_valid_t), .out_start(out_start_t),
    .out_last(out_last_t), .out_data(out_data_t), .err_restart(err_t)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sat8(input int v);
    int s;
    s = v > 127 ? 127 : (v < -128 ? -128 : v);
    return s[7:0];
  endfunction

  function automatic logic [7:0] trn8(input int v);
    return v[7:0];
  endfunction

  function automatic int clampd(input int d);
    return d == 0 ? 1 : (d > 8 ? 8 : d);
  endfunction

  function automatic int rnd();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic row(input bit st, input int c0, input int c1, input int c2, input int c3);
    int c[N];
    bit err_exp;
    c = '{c0, c1, c2, c3};
    in_valid = 1'b1;
    in_start = st;
    in_data = {c3[7:0], c2[7:0], c1[7:0], c0[7:0]};
    chk("row_in_ready", in_ready, 1);
    chk("row_in_ready_t", in_ready_t, 1);
    err_exp = 1'b0;
    if (st) begin
      err_exp = m_cnt != 0;
      m_depth = clampd(int'(cfg_depth));
      m_mode = cfg_mode;
      m_cnt = 1;
      m_acc = c;
    end else if (m_cnt != 0) begin
      m_cnt++;
      for (int i = 0; i < N; i++)
        m_acc[i] = m_mode ? (c[i] > m_acc[i] ? c[i] : m_acc[i]) : m_acc[i] + c[i];
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_start = 1'b0;
    chk("err_restart", err_restart, err_exp);
    chk("err_restart_t", err_t, err_exp);
  endtask

  task automatic drain(input int stall_at, input int stall_len, input int abort_at);
    logic [7:0] es, et;
    int ns;
    for (int p = 0; p < N; p++) begin
      if (p == abort_at) begin
        res = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_start", out_start, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 1);
        res = 1'b0;
        m_cnt = 0;
        out_ready = 1'b1;
        return;
      end
      es = sat8(m_acc[N-1-p]);
      et = trn8(m_acc[N-1-p]);
      ns = p == stall_at ? stall_len : 0;
      for (int s = 0; s <= ns; s++) begin
        out_ready = s == ns;
        chk("out_valid", out_valid, 1);
        chk("out_start", out_start, p == 0);
        chk("out_last", out_last, p == N - 1);
        chk("out_data_sat", out_data, es);
        chk("out_data_trunc", out_data_t, et);
        chk("out_valid_t", out_valid_t, 1);
        chk("out_last_t", out_last_t, p == N - 1);
        chk("drain_in_ready", in_ready, 0);
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
    chk("end_out_valid", out_valid, 0);
    chk("end_out_start", out_start_t, 0);
    chk("end_in_ready", in_ready, 1);
    m_cnt = 0;
  endtask

  initial begin
    #1 res = 1'b1;
    #2;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_start", out_start, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_err", err_restart, 0);
    chk("reset_out_data", out_data, 0);
    res = 1'b0;
    @(posedge clk); #1;
    row(0, 50, 50, 50, 50);
    chk("orphan_row_ignored", out_valid, 0);
    cfg_depth = 2; cfg_mode = 0;
    row(1, 1, 2, 3, 4);
    row(0, 10, 20, 30, 40);
    drain(-1, 0, -1);
    cfg_depth = 4;
    row(1, 100, 100, 100, 100);
    repeat (3) row(0, 100, 100, 100, 100);
    drain(-1, 0, -1);
    row(1, -100, -100, -100, -100);
    repeat (3) row(0, -100, -100, -100, -100);
    drain(-1, 0, -1);
    cfg_depth = 3; cfg_mode = 1;
    row(1, -5, -9, -9, -9);
    row(0, 7, -2, -2, -2);
    row(0, 3, -4, -4, -4);
    drain(-1, 0, -1);
    row(1, -9, -9, -9, -9);
    row(0, -2, -2, -2, -2);
    row(0, -4, -4, -4, -4);
    drain(-1, 0, -1);
    cfg_depth = 2; cfg_mode = 0;
    row(1, 12, -34, 56, -78);
    row(0, 21, 43, -65, 87);
    in_valid = 1'b1; in_start = 1'b1; in_data = {8'd9, 8'd8, 8'd7, 8'd6};
    cfg_depth = 1;
    drain(2, 3, -1);
    row(1, 6, 7, 8, 9);
    drain(-1, 0, -1);
    cfg_depth = 3;
    row(1, 2, 2, 2, 2);
    row(0, 3, 3, 3, 3);
    row(1, 5, 5, 5, 5);
    row(0, 1, 1, 1, 1);
    row(0, 1, 1, 1, 1);
    drain(-1, 0, -1);
    cfg_depth = 1;
    row(1, 11, 22, 33, 44);
    drain(-1, 0, 2);
    cfg_depth = 0;
    row(1, 1, 2, 3, 4);
    drain(-1, 0, -1);
    for (int g = 0; g < 30; g++) begin
      int d;
      cfg_depth = 4'($urandom_range(0, 15));
      cfg_mode = 1'($urandom_range(0, 1));
      row(1, rnd(), rnd(), rnd(), rnd());
      d = m_depth;
      for (int r = 1; r < d; r++) begin
        if ($urandom_range(0, 3) == 0) begin
          cfg_depth = 4'($urandom_range(0, 15));
          cfg_mode = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        row(0, rnd(), rnd(), rnd(), rnd());
      end
      drain(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), -1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
